// File: rtl/arith_multicycle_ctrl.sv
// Multi-cycle control FSM for the arithmetic machine datapath.
// Fetches each instruction with a req/ready handshake, latches it into IR,
// decodes it, then sequences EXECUTE and WRITEBACK. The regfile write and the
// PC update pulse once per instruction. An unrecognised instruction parks the
// machine in HALT with except raised until reset.
// Control outputs are decoded combinationally from the registered state and
// the IR, so they are free of input-to-output paths apart from reset gating.

module arith_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic             imem_req,
  output logic [31:0]      inst,
  output logic             pc_enable,
  output logic             writeenable,
  output logic             rd_src,
  output logic [1:0]       alu_src2,
  output logic [2:0]       alu_op,
  output logic             except,
  output logic             busy,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_HALT      = 3'd4
  } state_t;

  typedef struct packed {
    logic       legal;
    logic       rd_src;
    logic [1:0] alu_src2;
    logic [2:0] alu_op;
  } dec_t;

  // Opcodes and R-type function codes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;
  localparam logic [2:0] ALU_AND = 3'd4;
  localparam logic [2:0] ALU_OR  = 3'd5;
  localparam logic [2:0] ALU_NOR = 3'd6;
  localparam logic [2:0] ALU_XOR = 3'd7;

  // Second-operand selects
  localparam logic [1:0] SRC2_RT   = 2'd0;
  localparam logic [1:0] SRC2_SEXT = 2'd1;
  localparam logic [1:0] SRC2_ZEXT = 2'd2;
  localparam logic [1:0] SRC2_HI   = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Instruction classifier: legal flag plus the datapath controls it needs.
  // lui ignores its rs field, so a nonzero rs still executes normally.
  function automatic dec_t decode_inst(input logic [5:0] opcode,
                                       input logic [5:0] funct);
    dec_t d;
    d = dec_t'(7'd0);
    case (opcode)
      OP_RTYPE: begin
        d.rd_src   = 1'b0;
        d.alu_src2 = SRC2_RT;
        case (funct)
          FN_ADD:  begin d.legal = 1'b1; d.alu_op = ALU_ADD; end
          FN_SUB:  begin d.legal = 1'b1; d.alu_op = ALU_SUB; end
          FN_AND:  begin d.legal = 1'b1; d.alu_op = ALU_AND; end
          FN_OR:   begin d.legal = 1'b1; d.alu_op = ALU_OR;  end
          FN_NOR:  begin d.legal = 1'b1; d.alu_op = ALU_NOR; end
          FN_XOR:  begin d.legal = 1'b1; d.alu_op = ALU_XOR; end
          default: d = dec_t'(7'd0);
        endcase
      end
      OP_ADDI: d = '{legal: 1'b1, rd_src: 1'b1, alu_src2: SRC2_SEXT, alu_op: ALU_ADD};
      OP_ANDI: d = '{legal: 1'b1, rd_src: 1'b1, alu_src2: SRC2_ZEXT, alu_op: ALU_AND};
      OP_ORI:  d = '{legal: 1'b1, rd_src: 1'b1, alu_src2: SRC2_ZEXT, alu_op: ALU_OR};
      OP_XORI: d = '{legal: 1'b1, rd_src: 1'b1, alu_src2: SRC2_ZEXT, alu_op: ALU_XOR};
      OP_LUI:  d = '{legal: 1'b1, rd_src: 1'b1, alu_src2: SRC2_HI,   alu_op: ALU_OR};
      default: d = dec_t'(7'd0);
    endcase
    return d;
  endfunction

  state_t           state_r;
  state_t           state_n_s;
  logic [31:0]      inst_r;
  logic [CNT_W-1:0] retired_r;
  logic             pending_r;   // a fetch request went unanswered last cycle
  dec_t             dec_s;

  logic             imem_req_s;
  logic             we_s;
  logic             pc_s;
  logic             rd_src_s;
  logic [1:0]       alu_src2_s;
  logic [2:0]       alu_op_s;
  logic             except_s;
  logic             busy_s;

  assign dec_s = decode_inst(inst_r[31:26], inst_r[5:0]);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Instruction register: captured only on an accepted fetch
  always_ff @(posedge clock) begin
    if (reset) begin
      inst_r <= 32'd0;
    end else if ((state_r == ST_FETCH) && imem_ready) begin
      inst_r <= imem_rdata;
    end else begin
      inst_r <= inst_r;
    end
  end

  // Retired-instruction counter, bumped on every completed writeback
  always_ff @(posedge clock) begin
    if (reset) begin
      retired_r <= CNT_ZERO;
    end else if (state_r == ST_WRITEBACK) begin
      retired_r <= retired_r + CNT_ONE;
    end else begin
      retired_r <= retired_r;
    end
  end

  // Tracks an outstanding fetch so busy rises while memory keeps us waiting
  always_ff @(posedge clock) begin
    if (reset) begin
      pending_r <= 1'b0;
    end else begin
      pending_r <= (state_r == ST_FETCH) && !imem_ready;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_n_s  = state_r;
    imem_req_s = 1'b0;
    we_s       = 1'b0;
    pc_s       = 1'b0;
    rd_src_s   = 1'b0;
    alu_src2_s = 2'd0;
    alu_op_s   = 3'd0;
    except_s   = 1'b0;
    busy_s     = 1'b0;
    case (state_r)
      ST_FETCH: begin
        imem_req_s = 1'b1;
        busy_s     = (retired_r != CNT_ZERO) || pending_r;
        if (imem_ready) begin
          state_n_s = ST_DECODE;
        end else begin
          state_n_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        busy_s = 1'b1;
        if (dec_s.legal) begin
          state_n_s = ST_EXECUTE;
        end else begin
          state_n_s = ST_HALT;
        end
      end
      ST_EXECUTE: begin
        busy_s     = 1'b1;
        rd_src_s   = dec_s.rd_src;
        alu_src2_s = dec_s.alu_src2;
        alu_op_s   = dec_s.alu_op;
        state_n_s  = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        busy_s     = 1'b1;
        rd_src_s   = dec_s.rd_src;
        alu_src2_s = dec_s.alu_src2;
        alu_op_s   = dec_s.alu_op;
        we_s       = 1'b1;
        pc_s       = 1'b1;
        state_n_s  = ST_FETCH;
      end
      ST_HALT: begin
        except_s  = 1'b1;
        state_n_s = ST_HALT;
      end
      default: begin
        // Unreachable encoding: fail safe into HALT
        except_s  = 1'b1;
        state_n_s = ST_HALT;
      end
    endcase
  end

  // Reset suppresses the handshake and the side-effect pulses in the same cycle
  assign imem_req    = imem_req_s & ~reset;
  assign writeenable = we_s & ~reset;
  assign pc_enable   = pc_s & ~reset;
  assign rd_src      = rd_src_s;
  assign alu_src2    = alu_src2_s;
  assign alu_op      = alu_op_s;
  assign except      = except_s;
  assign busy        = busy_s;
  assign inst        = inst_r;
  assign retired     = retired_r;

  arith_multicycle_ctrl_checker u_checker (
    .clock       (clock),
    .reset       (reset),
    .imem_req    (imem_req),
    .writeenable (writeenable),
    .pc_enable   (pc_enable),
    .except      (except),
    .busy        (busy)
  );

endmodule

// Protocol properties of the controller outputs
module arith_multicycle_ctrl_checker (
  input logic clock,
  input logic reset,
  input logic imem_req,
  input logic writeenable,
  input logic pc_enable,
  input logic except,
  input logic busy
);

  // Regfile write and PC advance always travel together
  a_pulse_pair: assert property (@(posedge clock) writeenable == pc_enable);

  // A halted machine issues nothing and reports idle
  a_halt_quiet: assert property (@(posedge clock)
    except |-> (!imem_req && !writeenable && !busy));

  // Writeback pulse never lasts more than one cycle
  a_wb_single: assert property (@(posedge clock) disable iff (reset)
    writeenable |=> !writeenable);

endmodule

// File: tb/tb_arith_multicycle_ctrl.sv
// Self-checking bench for arith_multicycle_ctrl: directed scenarios with
// hand-computed expectations plus a randomized run, all compared every cycle
// against a behavioural model of the instruction sequencing.

module tb_arith_multicycle_ctrl;

  localparam int CW = 4;

  localparam logic [31:0] I_ADD  = 32'h012A4020;
  localparam logic [31:0] I_ORI  = 32'h3508FFFF;
  localparam logic [31:0] I_LUI  = 32'h3C081234;
  localparam logic [31:0] I_ADDI = 32'h2108FFFF;
  localparam logic [31:0] I_LW   = 32'h8C080000;
  localparam logic [31:0] I_BAD  = 32'h01294021;

  logic          clock = 1'b0;
  logic          reset;
  logic          imem_ready;
  logic [31:0]   imem_rdata;
  logic          imem_req;
  logic [31:0]   inst;
  logic          pc_enable;
  logic          writeenable;
  logic          rd_src;
  logic [1:0]    alu_src2;
  logic [2:0]    alu_op;
  logic          except;
  logic          busy;
  logic [CW-1:0] retired;

  int errors = 0;
  int checks = 0;

  // Model state: instruction progress counted in cycles since acceptance
  int          m_steps  = 0;   // 0 waiting on fetch, 1..3 cycles after accept
  bit          m_halted = 1'b0;
  logic [31:0] m_ir     = 32'd0;
  int          m_ret    = 0;
  bit          m_wait   = 1'b0;

  // Last sampled DUT outputs for directed checks
  logic          s_req, s_we, s_pc, s_rd, s_exc, s_busy;
  logic [1:0]    s_src2;
  logic [2:0]    s_op;
  logic [31:0]   s_inst;
  logic [CW-1:0] s_ret;

  arith_multicycle_ctrl #(.CNT_W(CW)) dut (
    .clock       (clock),
    .reset       (reset),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .imem_req    (imem_req),
    .inst        (inst),
    .pc_enable   (pc_enable),
    .writeenable (writeenable),
    .rd_src      (rd_src),
    .alu_src2    (alu_src2),
    .alu_op      (alu_op),
    .except      (except),
    .busy        (busy),
    .retired     (retired)
  );

  always #5 clock = ~clock;

  // Instruction table: {legal, rd_src, alu_src2, alu_op}
  function automatic logic [6:0] ref_decode(input logic [31:0] w);
    logic [5:0] op;
    logic [5:0] fn;
    op = w[31:26];
    fn = w[5:0];
    if (op == 6'h00) begin
      case (fn)
        6'h20:   return {1'b1, 1'b0, 2'd0, 3'd2};
        6'h22:   return {1'b1, 1'b0, 2'd0, 3'd3};
        6'h24:   return {1'b1, 1'b0, 2'd0, 3'd4};
        6'h25:   return {1'b1, 1'b0, 2'd0, 3'd5};
        6'h27:   return {1'b1, 1'b0, 2'd0, 3'd6};
        6'h26:   return {1'b1, 1'b0, 2'd0, 3'd7};
        default: return 7'd0;
      endcase
    end
    case (op)
      6'h08:   return {1'b1, 1'b1, 2'd1, 3'd2};
      6'h0c:   return {1'b1, 1'b1, 2'd2, 3'd4};
      6'h0d:   return {1'b1, 1'b1, 2'd2, 3'd5};
      6'h0e:   return {1'b1, 1'b1, 2'd2, 3'd7};
      6'h0f:   return {1'b1, 1'b1, 2'd3, 3'd5};
      default: return 7'd0;
    endcase
  endfunction

  // Random legal instruction with random register/immediate fields
  function automatic logic [31:0] legal_rand();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 10);
    case (k)
      0: begin w[31:26] = 6'h00; w[5:0] = 6'h20; end
      1: begin w[31:26] = 6'h00; w[5:0] = 6'h22; end
      2: begin w[31:26] = 6'h00; w[5:0] = 6'h24; end
      3: begin w[31:26] = 6'h00; w[5:0] = 6'h25; end
      4: begin w[31:26] = 6'h00; w[5:0] = 6'h27; end
      5: begin w[31:26] = 6'h00; w[5:0] = 6'h26; end
      6: w[31:26] = 6'h08;
      7: w[31:26] = 6'h0c;
      8: w[31:26] = 6'h0d;
      9: w[31:26] = 6'h0e;
      default: w[31:26] = 6'h0f;
    endcase
    return w;
  endfunction

  // Behavioural model advances on each clock from the inputs of that cycle
  always @(posedge clock) begin
    logic [6:0] d;
    d = ref_decode(m_ir);
    if (reset) begin
      m_steps  <= 0;
      m_halted <= 1'b0;
      m_ir     <= 32'd0;
      m_ret    <= 0;
      m_wait   <= 1'b0;
    end else if (!m_halted) begin
      if (m_steps == 0) begin
        if (imem_ready) begin
          m_ir    <= imem_rdata;
          m_steps <= 1;
          m_wait  <= 1'b0;
        end else begin
          m_wait  <= 1'b1;
        end
      end else if (m_steps == 1) begin
        if (d[6]) m_steps <= 2;
        else      m_halted <= 1'b1;
      end else if (m_steps == 2) begin
        m_steps <= 3;
      end else begin
        m_ret   <= (m_ret + 1) % (1 << CW);
        m_steps <= 0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: apply inputs, compare every output against the model, advance
  task automatic tick(input bit rst, input bit rdy, input logic [31:0] data);
    logic [6:0]  d;
    logic [46:0] act_v, exp_v;
    logic [CW-1:0] r;
    bit ctl, e_req, e_we, e_busy;
    reset = rst;
    imem_ready = rdy;
    imem_rdata = data;
    #2;
    s_req = imem_req; s_we = writeenable; s_pc = pc_enable; s_rd = rd_src;
    s_src2 = alu_src2; s_op = alu_op; s_exc = except; s_busy = busy;
    s_inst = inst; s_ret = retired;
    if (rst) begin
      chk("pulses_in_reset", 64'({writeenable, pc_enable}), 64'd0);
    end else begin
      d      = ref_decode(m_ir);
      r      = m_ret[CW-1:0];
      ctl    = !m_halted && (m_steps == 2 || m_steps == 3);
      e_req  = !m_halted && (m_steps == 0);
      e_we   = !m_halted && (m_steps == 3);
      e_busy = m_halted ? 1'b0 : ((m_steps != 0) ? 1'b1 : ((m_ret != 0) || m_wait));
      exp_v  = {e_req, e_we, e_we, (ctl ? d[5:0] : 6'd0), m_halted, e_busy, m_ir, r};
      act_v  = {imem_req, writeenable, pc_enable, rd_src, alu_src2, alu_op,
                except, busy, inst, retired};
      chk("cycle_outputs", 64'(act_v), 64'(exp_v));
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    int n;
    int bad;
    bit rst;
    reset = 1'b1;
    imem_ready = 1'b0;
    imem_rdata = 32'd0;
    @(negedge clock);

    // add with memory always ready: WB on cycle 4
    tick(1'b1, 1'b0, 32'd0);
    tick(1'b0, 1'b1, I_ADD);
    chk("t1_c1_req", 64'(s_req), 64'd1);
    tick(1'b0, 1'b0, 32'd0);
    tick(1'b0, 1'b0, 32'd0);
    chk("t1_c3_ctl", 64'({s_rd, s_src2, s_op}), 64'({1'b0, 2'd0, 3'd2}));
    chk("t1_c3_we", 64'({s_we, s_pc}), 64'd0);
    tick(1'b0, 1'b0, 32'd0);
    chk("t1_c4_pulses", 64'({s_we, s_pc}), 64'd3);
    tick(1'b0, 1'b0, 32'd0);
    chk("t1_retired", 64'(s_ret), 64'd1);
    chk("t1_c5_we", 64'(s_we), 64'd0);

    // ori after five wait cycles
    tick(1'b1, 1'b0, 32'd0);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, $urandom);
      n += int'(s_req);
      if (i == 0) chk("t2_busy_idle", 64'(s_busy), 64'd0);
      if (i == 1) chk("t2_busy_wait", 64'(s_busy), 64'd1);
    end
    tick(1'b0, 1'b1, I_ORI);  n += int'(s_req);
    tick(1'b0, 1'b0, 32'd0);  n += int'(s_req);
    tick(1'b0, 1'b0, 32'd0);  n += int'(s_req);
    chk("t2_c8_ctl", 64'({s_rd, s_src2, s_op}), 64'({1'b1, 2'd2, 3'd5}));
    tick(1'b0, 1'b0, 32'd0);  n += int'(s_req);
    chk("t2_c9_pulses", 64'({s_we, s_pc}), 64'd3);
    chk("t2_req_cycles", 64'(n), 64'd6);

    // lui then addi
    tick(1'b1, 1'b0, 32'd0);
    tick(1'b0, 1'b1, I_LUI);
    tick(1'b0, 1'b0, 32'd0);
    chk("t3_ir", 64'(s_inst), 64'(I_LUI));
    tick(1'b0, 1'b0, 32'd0);
    chk("t3_lui_ctl", 64'({s_rd, s_src2, s_op}), 64'({1'b1, 2'd3, 3'd5}));
    tick(1'b0, 1'b0, 32'd0);
    tick(1'b0, 1'b1, I_ADDI);
    tick(1'b0, 1'b0, 32'd0);
    tick(1'b0, 1'b0, 32'd0);
    chk("t3_addi_ctl", 64'({s_rd, s_src2, s_op}), 64'({1'b1, 2'd1, 3'd2}));
    tick(1'b0, 1'b0, 32'd0);
    tick(1'b0, 1'b0, 32'd0);
    chk("t3_retired", 64'(s_ret), 64'd2);

    // lw is illegal: halt from cycle 3 and hold until reset
    tick(1'b1, 1'b0, 32'd0);
    tick(1'b0, 1'b1, I_LW);
    tick(1'b0, 1'b1, I_ADD);
    tick(1'b0, 1'b1, I_ADD);
    chk("t4_c3_halt", 64'({s_exc, s_req, s_we, s_pc}), 64'h8);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b1, $urandom);
      if (!s_exc || s_req || s_we || s_pc || s_busy) bad++;
    end
    chk("t4_halt_hold", 64'(bad), 64'd0);
    chk("t4_ir_kept", 64'(s_inst), 64'(I_LW));
    tick(1'b1, 1'b0, 32'd0);
    tick(1'b0, 1'b0, 32'd0);
    chk("t4_after_reset", 64'({s_exc, s_req}), 64'd1);

    // reset landing on the writeback cycle
    tick(1'b1, 1'b0, 32'd0);
    tick(1'b0, 1'b1, I_ADD);
    tick(1'b0, 1'b0, 32'd0);
    tick(1'b0, 1'b0, 32'd0);
    tick(1'b1, 1'b0, 32'd0);
    chk("t5_wb_reset_pulses", 64'({s_we, s_pc}), 64'd0);
    tick(1'b0, 1'b0, 32'd0);
    chk("t5_next_fetch", 64'({s_req, s_we}), 64'd2);
    chk("t5_retired", 64'(s_ret), 64'd0);

    // sixteen back-to-back instructions wrap the 4-bit counter
    tick(1'b1, 1'b0, 32'd0);
    for (int k = 0; k < 16; k++) begin
      tick(1'b0, 1'b1, legal_rand());
      if (k == 15) chk("t6_ret_15", 64'(s_ret), 64'd15);
      tick(1'b0, 1'b0, 32'd0);
      tick(1'b0, 1'b0, 32'd0);
      tick(1'b0, 1'b0, 32'd0);
    end
    tick(1'b0, 1'b0, 32'd0);
    chk("t6_wrap", 64'(s_ret), 64'd0);
    tick(1'b0, 1'b1, I_BAD);
    tick(1'b0, 1'b0, 32'd0);
    tick(1'b0, 1'b0, 32'd0);
    chk("t6_bad_funct_halt", 64'({s_exc, s_we}), 64'd2);

    // randomized traffic against the model
    tick(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 3000; i++) begin
      if (m_halted) rst = ($urandom_range(0, 5) == 0);
      else          rst = ($urandom_range(0, 249) == 0);
      tick(rst, ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 7) == 0) ? $urandom : legal_rand());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
